doce_tx_arbiter: RTL and testbench
==================================

DOCE_TX_ARBITER -- requirements
Module: doce_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, stream width in bytes.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports sN_axis_txd_tdata  input  DATA_WIDTH*8  requester N payload (N=0,1; applies to REQ-005..009).
REQ-005 SHALL have ports sN_axis_txd_tkeep  input  DATA_WIDTH  byte enables.
REQ-006 SHALL have ports sN_axis_txd_tuser  input  17  per-packet sideband, sampled every beat.
REQ-007 SHALL have ports sN_axis_txd_tlast  input  1  last beat of packet.
REQ-008 SHALL have ports sN_axis_txd_tvalid  input  1  beat valid.
REQ-009 SHALL have ports sN_axis_txd_tready  output  1  beat accepted.
REQ-010 SHALL have ports m_axis_txd_tdata/tkeep/tuser/tlast/tvalid  output  DATA_WIDTH*8/DATA_WIDTH/17/1/1  merged stream to tx framing.
REQ-011 SHALL have port m_axis_txd_tready  input  1  downstream ready.
REQ-012 SHALL have port grant  output  2  one-hot current owner, 00 when idle.
REQ-013 SHALL have ports pkt_cnt0, pkt_cnt1  output  32  packets forwarded per requester.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1; grant = 00/01/10 respectively.
REQ-015 SHALL, in IDLE, pick a requester from sN tvalid using round-robin pointer rr (last granted index gets lowest priority) and move to GNTx next cycle.
REQ-016 SHALL, in IDLE with only one tvalid, grant that requester regardless of rr.
REQ-017 SHALL hold the grant for whole packet; non-granted sN tready = 0 at all times.
REQ-018 SHALL return to IDLE the cycle after the granted tlast beat is accepted, update rr to that index, and never grant mid-packet to the other requester (one bubble cycle between packets).
REQ-019 SHALL drive sN tready = 0 in IDLE.
REQ-020 SHALL register output through a one-entry slice: granted tready = ~m_tvalid | m_tready; accepted beat appears on m_axis one cycle later (latency 1).
REQ-021 SHALL keep m_axis data/keep/user/last stable while m_tvalid=1 and m_tready=0.
REQ-022 SHALL clear m_tvalid on m_tready with no new beat loaded; back-to-back beats SHALL sustain one beat/cycle.
REQ-023 SHALL forward tuser, tkeep unmodified per beat.
REQ-024 SHALL allow tlast on first beat (single-beat packet) with same FSM sequence.
REQ-025 SHALL ignore sN tvalid deassertion mid-packet (bubble, grant held).

Reset
REQ-026 SHALL on reset assertion, at any time, go to IDLE, rr=1 (requester 0 wins first tie), grant=00, m_tvalid=0, m_tlast=0, m_tdata/tkeep/tuser=0, sN tready=0, pkt counters=0.
REQ-027 SHALL discard any partially forwarded packet on reset; no recovery of its remaining beats.
REQ-028 SHALL leave IDLE no earlier than the first clk edge after reset deassertion.

Configuration
REQ-029 SHALL, with DOCE_TX_ARB_PKT_CNT_EN defined, increment pkt_cnt0/pkt_cnt1 by 1 at each accepted tlast beat from requester 0/1, wrapping 0xFFFFFFFF -> 0.
REQ-030 SHALL, without DOCE_TX_ARB_PKT_CNT_EN, tie pkt_cnt0 and pkt_cnt1 to 0 with no counter logic.

Verification
REQ-031 SHALL cover: s0 and s1 both valid from reset, 3-beat packets each -> s0 packet first, then bubble, then s1; m_axis order s0 b0..b2, s1 b0..b2.
REQ-032 SHALL cover: s0 sends 4 consecutive 2-beat packets while s1 idle -> all forwarded, grant 01 each, one idle cycle between packets.
REQ-033 SHALL cover: m_tready held 0 for 5 cycles mid-packet -> m_axis beat stable, granted tready=0 after slice fills, no beat lost or duplicated.
REQ-034 SHALL cover: s1 raises tvalid during s0 packet -> s1 tready stays 0 until s0 tlast accepted, then grant=10.
REQ-035 SHALL cover: reset pulsed during beat 2 of 4-beat s1 packet -> m_tvalid=0, grant=00 immediately; next arbitration grants s0 on tie.
REQ-036 SHALL cover (DOCE_TX_ARB_PKT_CNT_EN): pkt_cnt0 preset via force to 0xFFFFFFFF, one s0 packet -> pkt_cnt0=0, pkt_cnt1 unchanged.

Source files
------------

// File: rtl/doce_tx_arbiter.sv
// rtl/doce_tx_arbiter.sv - two-requester round-robin packet arbiter onto one registered stream.
// Optional per-requester packet counters: define DOCE_TX_ARB_PKT_CNT_EN.
module doce_tx_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH*8-1:0]   s0_axis_txd_tdata,
    input  logic [DATA_WIDTH-1:0]     s0_axis_txd_tkeep,
    input  logic [16:0]               s0_axis_txd_tuser,
    input  logic                      s0_axis_txd_tlast,
    input  logic                      s0_axis_txd_tvalid,
    output logic                      s0_axis_txd_tready,
    input  logic [DATA_WIDTH*8-1:0]   s1_axis_txd_tdata,
    input  logic [DATA_WIDTH-1:0]     s1_axis_txd_tkeep,
    input  logic [16:0]               s1_axis_txd_tuser,
    input  logic                      s1_axis_txd_tlast,
    input  logic                      s1_axis_txd_tvalid,
    output logic                      s1_axis_txd_tready,
    output logic [DATA_WIDTH*8-1:0]   m_axis_txd_tdata,
    output logic [DATA_WIDTH-1:0]     m_axis_txd_tkeep,
    output logic [16:0]               m_axis_txd_tuser,
    output logic                      m_axis_txd_tlast,
    output logic                      m_axis_txd_tvalid,
    input  logic                      m_axis_txd_tready,
    output logic [1:0]                grant,
    output logic [31:0]               pkt_cnt0,
    output logic [31:0]               pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_rr;
    logic [DATA_WIDTH*8-1:0]   r_m_tdata;
    logic [DATA_WIDTH-1:0]     r_m_tkeep;
    logic [16:0]               r_m_tuser;
    logic                      r_m_tlast;
    logic                      r_m_tvalid;
    logic                      w_slice_ready;
    logic                      w_acc0;
    logic                      w_acc1;
    logic                      w_sel1;

    assign m_axis_txd_tdata  = r_m_tdata;
    assign m_axis_txd_tkeep  = r_m_tkeep;
    assign m_axis_txd_tuser  = r_m_tuser;
    assign m_axis_txd_tlast  = r_m_tlast;
    assign m_axis_txd_tvalid = r_m_tvalid;

    // The slice can take a beat when empty or when its current beat leaves this cycle.
    assign w_slice_ready = ~r_m_tvalid | m_axis_txd_tready;
    assign w_acc0        = (r_state == GNT0) & s0_axis_txd_tvalid & w_slice_ready;
    assign w_acc1        = (r_state == GNT1) & s1_axis_txd_tvalid & w_slice_ready;
    assign w_sel1        = (r_state == GNT1);

    always_comb begin
        w_next_state       = r_state;
        s0_axis_txd_tready = 1'b0;
        s1_axis_txd_tready = 1'b0;
        grant              = 2'b00;
        case (r_state)
            IDLE: begin
                // r_rr holds the last granted index, which loses a tie.
                if (s0_axis_txd_tvalid && (!s1_axis_txd_tvalid || r_rr))
                    w_next_state = GNT0;
                else if (s1_axis_txd_tvalid)
                    w_next_state = GNT1;
            end
            GNT0: begin
                grant              = 2'b01;
                s0_axis_txd_tready = w_slice_ready;
                if (w_acc0 && s0_axis_txd_tlast)
                    w_next_state = IDLE;
            end
            GNT1: begin
                grant              = 2'b10;
                s1_axis_txd_tready = w_slice_ready;
                if (w_acc1 && s1_axis_txd_tlast)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr       <= 1'b1;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_acc0 && s0_axis_txd_tlast)
                r_rr <= 1'b0;
            else if (w_acc1 && s1_axis_txd_tlast)
                r_rr <= 1'b1;
            if (w_acc0 || w_acc1) begin
                r_m_tdata  <= w_sel1 ? s1_axis_txd_tdata : s0_axis_txd_tdata;
                r_m_tkeep  <= w_sel1 ? s1_axis_txd_tkeep : s0_axis_txd_tkeep;
                r_m_tuser  <= w_sel1 ? s1_axis_txd_tuser : s0_axis_txd_tuser;
                r_m_tlast  <= w_sel1 ? s1_axis_txd_tlast : s0_axis_txd_tlast;
                r_m_tvalid <= 1'b1;
            end else if (m_axis_txd_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

`ifdef DOCE_TX_ARB_PKT_CNT_EN
    logic [31:0] r_pkt_cnt0;
    logic [31:0] r_pkt_cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (w_acc0 && s0_axis_txd_tlast)
                r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
            if (w_acc1 && s1_axis_txd_tlast)
                r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_doce_tx_arbiter.sv
// tb/tb_doce_tx_arbiter.sv - directed self-checking bench for doce_tx_arbiter.
module tb_doce_tx_arbiter;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW*8-1:0]   s0_tdata, s1_tdata, m_tdata;
    logic [DW-1:0]     s0_tkeep, s1_tkeep, m_tkeep;
    logic [16:0]       s0_tuser, s1_tuser, m_tuser;
    logic              s0_tlast, s1_tlast, m_tlast;
    logic              s0_tvalid, s1_tvalid, m_tvalid;
    logic              s0_tready, s1_tready, m_tready;
    logic [1:0]        grant;
    logic [31:0]       pkt_cnt0, pkt_cnt1;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic [16:0]  u;
        logic         l;
        int           c;
    } beat_t;

    beat_t cap[$];
    int    n_cmp = 0, n_fail = 0;
    int    cyc = 0, viol = 0, g0 = 0, g1 = 0;
    int    base, g0_s, g1_s, n;
    logic  found;

    always #5 clk = ~clk;

    doce_tx_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .s0_axis_txd_tdata(s0_tdata), .s0_axis_txd_tkeep(s0_tkeep), .s0_axis_txd_tuser(s0_tuser),
        .s0_axis_txd_tlast(s0_tlast), .s0_axis_txd_tvalid(s0_tvalid), .s0_axis_txd_tready(s0_tready),
        .s1_axis_txd_tdata(s1_tdata), .s1_axis_txd_tkeep(s1_tkeep), .s1_axis_txd_tuser(s1_tuser),
        .s1_axis_txd_tlast(s1_tlast), .s1_axis_txd_tvalid(s1_tvalid), .s1_axis_txd_tready(s1_tready),
        .m_axis_txd_tdata(m_tdata), .m_axis_txd_tkeep(m_tkeep), .m_axis_txd_tuser(m_tuser),
        .m_axis_txd_tlast(m_tlast), .m_axis_txd_tvalid(m_tvalid), .m_axis_txd_tready(m_tready),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    function automatic logic [127:0] mk_data(input int src, input int pkt, input int b);
        logic [15:0] w;
        w = {src[3:0], pkt[3:0], b[7:0]};
        return {8{w}};
    endfunction

    function automatic logic [15:0] mk_keep(input int b);
        logic [15:0] k;
        k = 16'hFFFF;
        return k >> b;
    endfunction

    function automatic logic [16:0] mk_user(input int src, input int pkt, input int b);
        logic [15:0] w;
        w = {pkt[3:0], src[3:0], b[7:0]};
        return {src[0], w};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input int idx, input int src, input int pkt, input int b, input logic last);
        chk($sformatf("present%0d", idx), 128'(cap.size() > idx), 128'd1);
        if (cap.size() <= idx) return;
        chk($sformatf("data%0d", idx), cap[idx].d, mk_data(src, pkt, b));
        chk($sformatf("keep%0d", idx), 128'(cap[idx].k), 128'(mk_keep(b)));
        chk($sformatf("user%0d", idx), 128'(cap[idx].u), 128'(mk_user(src, pkt, b)));
        chk($sformatf("last%0d", idx), 128'(cap[idx].l), 128'(last));
    endtask

    task automatic drive(input int src, input logic v, input int pkt, input int b, input logic l);
        if (src == 0) begin
            s0_tvalid = v; s0_tlast = l;
            s0_tdata = v ? mk_data(0, pkt, b) : '0;
            s0_tkeep = v ? mk_keep(b) : '0;
            s0_tuser = v ? mk_user(0, pkt, b) : '0;
        end else begin
            s1_tvalid = v; s1_tlast = l;
            s1_tdata = v ? mk_data(1, pkt, b) : '0;
            s1_tkeep = v ? mk_keep(b) : '0;
            s1_tuser = v ? mk_user(1, pkt, b) : '0;
        end
    endtask

    task automatic send(input int src, input int pkt, input int nb);
        int   k;
        logic acc;
        for (int b = 0; b < nb; b++) begin
            drive(src, 1'b1, pkt, b, b == nb - 1);
            k = 0;
            acc = 1'b0;
            while (!acc && k < 100) begin
                @(negedge clk);
                acc = (src == 0) ? s0_tready : s1_tready;
                k++;
                @(posedge clk); #1;
            end
            chk($sformatf("send_timeout_s%0d", src), 128'(acc), 128'd1);
        end
        drive(src, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Protocol watchdog: ownership of tready and capture of every beat leaving the slice.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (grant == 2'b11) viol++;
            if (grant == 2'b00 && (s0_tready || s1_tready)) viol++;
            if (grant == 2'b01 && (s1_tready || s0_tready !== (!m_tvalid || m_tready))) viol++;
            if (grant == 2'b10 && (s0_tready || s1_tready !== (!m_tvalid || m_tready))) viol++;
            if (grant == 2'b01) g0++;
            if (grant == 2'b10) g1++;
            if (m_tvalid && m_tready)
                cap.push_back('{d: m_tdata, k: m_tkeep, u: m_tuser, l: m_tlast, c: cyc});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        m_tready = 1'b1;
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        idle_cycles(2);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_mlast", m_tlast, 1'b0);
        chk("rst_mdata", m_tdata, 128'd0);
        chk("rst_mkeep", m_tkeep, 16'd0);
        chk("rst_muser", m_tuser, 17'd0);
        chk("rst_cnt0", pkt_cnt0, 32'd0);
        chk("rst_cnt1", pkt_cnt1, 32'd0);

        // Both requesters valid while reset is still held: nothing may be granted.
        drive(0, 1'b1, 0, 0, 1'b0);
        drive(1, 1'b1, 0, 0, 1'b0);
        idle_cycles(1);
        chk("rst_hold_grant", grant, 2'b00);
        chk("rst_tready0", s0_tready, 1'b0);
        chk("rst_tready1", s1_tready, 1'b0);
        reset = 1'b0;

        // Tie from reset: s0 first, one bubble, then s1.
        base = cap.size();
        fork
            send(0, 0, 3);
            send(1, 0, 3);
            begin
                @(negedge clk); chk("t1_idle", grant, 2'b00);
                @(negedge clk); chk("t1_g0", grant, 2'b01); chk("t1_lat", m_tvalid, 1'b0);
                @(negedge clk); chk("t1_first_v", m_tvalid, 1'b1); chk("t1_first_d", m_tdata, mk_data(0, 0, 0));
                @(negedge clk);
                @(negedge clk); chk("t1_bubble", grant, 2'b00); chk("t1_lastbeat", m_tlast, 1'b1);
                @(negedge clk); chk("t1_g1", grant, 2'b10);
            end
        join
        idle_cycles(3);
        chk("t1_count", cap.size() - base, 6);
        for (int b = 0; b < 3; b++) chk_beat(base + b, 0, 0, b, b == 2);
        for (int b = 0; b < 3; b++) chk_beat(base + 3 + b, 1, 0, b, b == 2);

        // s1 arrives mid s0 packet: held off until s0 finishes.
        base = cap.size();
        found = 1'b0;
        fork
            send(0, 1, 3);
            begin idle_cycles(2); send(1, 1, 2); end
            begin
                n = 0;
                while (!found && n < 30) begin
                    @(negedge clk);
                    found = (grant == 2'b10);
                    n++;
                end
                chk("t34_g1_seen", found, 1'b1);
                chk("t34_s0_done", cap[$].d, mk_data(0, 1, 2));
            end
        join
        idle_cycles(3);
        chk("t34_count", cap.size() - base, 5);
        for (int b = 0; b < 3; b++) chk_beat(base + b, 0, 1, b, b == 2);
        for (int b = 0; b < 2; b++) chk_beat(base + 3 + b, 1, 1, b, b == 1);

        // Four 2-beat s0 packets back to back: one idle cycle between packets.
        base = cap.size();
        g0_s = g0;
        g1_s = g1;
        for (int p = 0; p < 4; p++) send(0, 2 + p, 2);
        chk("t32_g0_cycles", g0 - g0_s, 8);
        chk("t32_g1_cycles", g1 - g1_s, 0);
        idle_cycles(3);
        chk("t32_count", cap.size() - base, 8);
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 2; b++) chk_beat(base + 2 * p + b, 0, 2 + p, b, b == 1);
        for (int p = 1; p < 4; p++)
            if (cap.size() > base + 2 * p + 1)
                chk($sformatf("t32_spacing%0d", p), cap[base + 2 * p + 1].c - cap[base + 2 * p - 1].c, 3);

        // Downstream stall of 5 cycles mid-packet.
        base = cap.size();
        fork
            send(0, 6, 4);
            begin
                n = 0;
                while (cap.size() < base + 2 && n < 50) begin @(posedge clk); n++; end
                #1 m_tready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("t33_valid%0d", i), m_tvalid, 1'b1);
                    chk($sformatf("t33_data%0d", i), m_tdata, mk_data(0, 6, 2));
                    chk($sformatf("t33_tready%0d", i), s0_tready, 1'b0);
                end
                @(posedge clk); #1 m_tready = 1'b1;
            end
        join
        idle_cycles(3);
        chk("t33_count", cap.size() - base, 4);
        for (int b = 0; b < 4; b++) chk_beat(base + b, 0, 6, b, b == 3);

        // Reset during beat 2 of a 4-beat s1 packet; rr is 0 here, reset must restore s0 priority.
        base = cap.size();
        drive(1, 1'b1, 7, 0, 1'b0);
        idle_cycles(1);
        idle_cycles(1);
        drive(1, 1'b1, 7, 1, 1'b0);
        idle_cycles(1);
        drive(1, 1'b1, 7, 2, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("t35_mvalid", m_tvalid, 1'b0);
        chk("t35_grant", grant, 2'b00);
        chk("t35_tready1", s1_tready, 1'b0);
        chk("t35_mdata", m_tdata, 128'd0);
        drive(1, 1'b0, 0, 0, 1'b0);
        idle_cycles(1);
        reset = 1'b0;
        chk("t35_partial", cap.size() - base, 1);
        chk_beat(base, 1, 7, 0, 1'b0);
        fork
            send(0, 8, 1);
            send(1, 8, 1);
        join
        idle_cycles(3);
        chk("t35_count", cap.size() - base, 3);
        chk_beat(base + 1, 0, 8, 0, 1'b1);
        chk_beat(base + 2, 1, 8, 0, 1'b1);

`ifdef DOCE_TX_ARB_PKT_CNT_EN
        chk("cnt0_after_rst", pkt_cnt0, 32'd1);
        chk("cnt1_after_rst", pkt_cnt1, 32'd1);
        force dut.r_pkt_cnt0 = 32'hFFFF_FFFF;
        #1;
        release dut.r_pkt_cnt0;
        chk("cnt0_preset", pkt_cnt0, 32'hFFFF_FFFF);
        send(0, 9, 2);
        idle_cycles(2);
        chk("cnt0_wrap", pkt_cnt0, 32'd0);
        chk("cnt1_unchanged", pkt_cnt1, 32'd1);
`else
        chk("cnt0_tied", pkt_cnt0, 32'd0);
        chk("cnt1_tied", pkt_cnt1, 32'd0);
`endif

        chk("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
